// File: rtl/tile_sequencer.sv
// Tile sequencer: walks one matrix tile through weight preload, input streaming,
// pipeline drain and result write-back, driving the buffer/MAC/accumulator strobes.
module tile_sequencer #(
   parameter int ARR_SIZE = 4,
   parameter int K_W      = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        abort,
   input  logic [K_W-1:0]              cfg_k,
   input  logic [14:0]                 cfg_wt_base,
   input  logic [14:0]                 cfg_inp_base,
   input  logic [3:0]                  cfg_op_base,
   output logic                        busy,
   output logic                        done,
   output logic                        wt_rd_en,
   output logic [14:0]                 wt_addr,
   output logic                        inp_rd_en,
   output logic [14:0]                 inp_addr,
   output logic                        mac_load_wt,
   output logic                        mac_valid,
   output logic                        acc_reset,
   output logic [$clog2(ARR_SIZE)-1:0] acc_sel,
   output logic                        op_wr_en,
   output logic [3:0]                  op_addr
);

   localparam int SEL_W = $clog2(ARR_SIZE);
   localparam int CNT_W = (K_W > SEL_W + 2) ? K_W : SEL_W + 2;
   localparam logic [CNT_W-1:0] LAST_N     = CNT_W'(ARR_SIZE - 1);
   localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(2 * ARR_SIZE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD_WT = 3'd1,
      S_STREAM  = 3'd2,
      S_DRAIN   = 3'd3,
      S_WRITE   = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic [K_W-1:0]   k_r;
   logic [14:0]      wt_base_r;
   logic [14:0]      inp_base_r;
   logic [3:0]       op_base_r;

   logic             latch_s;
   logic             abort_act_s;
   logic [CNT_W-1:0] k_last_s;
   logic [14:0]      wt_base_s;
   logic [14:0]      inp_base_s;
   logic [3:0]       op_base_s;

   logic             busy_s;
   logic             done_s;
   logic             wt_rd_en_s;
   logic [14:0]      wt_addr_s;
   logic             inp_rd_en_s;
   logic [14:0]      inp_addr_s;
   logic             acc_reset_s;
   logic [SEL_W-1:0] acc_sel_s;
   logic             op_wr_en_s;
   logic [3:0]       op_addr_s;

   assign latch_s     = (state_r == S_IDLE) && start && (cfg_k != {K_W{1'b0}});
   assign abort_act_s = abort && (state_r != S_IDLE);
   assign k_last_s    = CNT_W'(k_r) - CNT_ONE;

   // Outputs are registered from the next state, so the shadow bases must be
   // visible on the same edge that captures them.
   assign wt_base_s  = latch_s ? cfg_wt_base  : wt_base_r;
   assign inp_base_s = latch_s ? cfg_inp_base : inp_base_r;
   assign op_base_s  = latch_s ? cfg_op_base  : op_base_r;

   // State, phase counter and shadow configuration registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= S_IDLE;
         cnt_r      <= {CNT_W{1'b0}};
         k_r        <= {K_W{1'b0}};
         wt_base_r  <= 15'd0;
         inp_base_r <= 15'd0;
         op_base_r  <= 4'd0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         if (latch_s) begin
            k_r        <= cfg_k;
            wt_base_r  <= cfg_wt_base;
            inp_base_r <= cfg_inp_base;
            op_base_r  <= cfg_op_base;
         end else begin
            k_r        <= k_r;
            wt_base_r  <= wt_base_r;
            inp_base_r <= inp_base_r;
            op_base_r  <= op_base_r;
         end
      end
   end

   // Next-state and phase-counter logic; abort overrides every busy state.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      if (abort_act_s) begin
         state_s = S_IDLE;
         cnt_s   = {CNT_W{1'b0}};
      end else begin
         case (state_r)
            S_IDLE: begin
               cnt_s = {CNT_W{1'b0}};
               if (latch_s) begin
                  state_s = S_LOAD_WT;
               end else begin
                  state_s = S_IDLE;
               end
            end
            S_LOAD_WT: begin
               if (cnt_r == LAST_N) begin
                  state_s = S_STREAM;
                  cnt_s   = {CNT_W{1'b0}};
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end
            S_STREAM: begin
               if (cnt_r == k_last_s) begin
                  state_s = S_DRAIN;
                  cnt_s   = {CNT_W{1'b0}};
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end
            S_DRAIN: begin
               if (cnt_r == LAST_DRAIN) begin
                  state_s = S_WRITE;
                  cnt_s   = {CNT_W{1'b0}};
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end
            S_WRITE: begin
               if (cnt_r == LAST_N) begin
                  state_s = S_DONE;
                  cnt_s   = {CNT_W{1'b0}};
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end
            S_DONE: begin
               state_s = S_IDLE;
               cnt_s   = {CNT_W{1'b0}};
            end
            default: begin
               state_s = S_IDLE;
               cnt_s   = {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // Output decode from the upcoming state/count; addresses wrap at their widths.
   always_comb begin
      busy_s      = (state_s != S_IDLE);
      done_s      = 1'b0;
      wt_rd_en_s  = 1'b0;
      wt_addr_s   = 15'd0;
      inp_rd_en_s = 1'b0;
      inp_addr_s  = 15'd0;
      acc_reset_s = 1'b0;
      acc_sel_s   = {SEL_W{1'b0}};
      op_wr_en_s  = 1'b0;
      op_addr_s   = 4'd0;
      case (state_s)
         S_LOAD_WT: begin
            wt_rd_en_s  = 1'b1;
            wt_addr_s   = wt_base_s + 15'(cnt_s);
            acc_reset_s = (cnt_s == {CNT_W{1'b0}});
         end
         S_STREAM: begin
            inp_rd_en_s = 1'b1;
            inp_addr_s  = inp_base_s + 15'(cnt_s);
         end
         S_WRITE: begin
            op_wr_en_s = 1'b1;
            acc_sel_s  = SEL_W'(cnt_s);
            op_addr_s  = op_base_s + 4'(cnt_s);
         end
         S_DONE: begin
            done_s = 1'b1;
         end
         default: begin
            done_s = 1'b0;
         end
      endcase
   end

   // Output registers; MAC strobes trail the buffer read strobes by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         wt_rd_en    <= 1'b0;
         wt_addr     <= 15'd0;
         inp_rd_en   <= 1'b0;
         inp_addr    <= 15'd0;
         mac_load_wt <= 1'b0;
         mac_valid   <= 1'b0;
         acc_reset   <= 1'b0;
         acc_sel     <= {SEL_W{1'b0}};
         op_wr_en    <= 1'b0;
         op_addr     <= 4'd0;
      end else begin
         busy      <= busy_s;
         done      <= done_s;
         wt_rd_en  <= wt_rd_en_s;
         wt_addr   <= wt_addr_s;
         inp_rd_en <= inp_rd_en_s;
         inp_addr  <= inp_addr_s;
         acc_reset <= acc_reset_s;
         acc_sel   <= acc_sel_s;
         op_wr_en  <= op_wr_en_s;
         op_addr   <= op_addr_s;
         if (abort_act_s) begin
            mac_load_wt <= 1'b0;
            mac_valid   <= 1'b0;
         end else begin
            mac_load_wt <= wt_rd_en;
            mac_valid   <= inp_rd_en;
         end
      end
   end

endmodule

// File: tb/tb_tile_sequencer.sv
// Scoreboard bench for tile_sequencer: directed tiles push expected strobe events,
// a negedge monitor pops and compares them whenever the DUT raises a strobe.
module tb_tile_sequencer;
   localparam int N  = 4;
   localparam int KW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [KW-1:0] cfg_k = '0;
   logic [14:0]   cfg_wt_base = '0;
   logic [14:0]   cfg_inp_base = '0;
   logic [3:0]    cfg_op_base = '0;
   logic          busy, done, wt_rd_en, inp_rd_en, mac_load_wt, mac_valid, acc_reset, op_wr_en;
   logic [14:0]   wt_addr, inp_addr;
   logic [1:0]    acc_sel;
   logic [3:0]    op_addr;

   typedef struct {int c; int v;} ev_t;
   // 0 wt, 1 inp, 2 op, 3 mac_load_wt, 4 mac_valid, 5 acc_reset, 6 done
   ev_t qs[7][$];
   int  cyc = 0, checks = 0, errors = 0, bw_s = -1, bw_e = -2, t0 = 0;

   tile_sequencer #(.ARR_SIZE(N), .K_W(KW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_k(cfg_k),
      .cfg_wt_base(cfg_wt_base), .cfg_inp_base(cfg_inp_base), .cfg_op_base(cfg_op_base),
      .busy(busy), .done(done), .wt_rd_en(wt_rd_en), .wt_addr(wt_addr),
      .inp_rd_en(inp_rd_en), .inp_addr(inp_addr), .mac_load_wt(mac_load_wt),
      .mac_valid(mac_valid), .acc_reset(acc_reset), .acc_sel(acc_sel),
      .op_wr_en(op_wr_en), .op_addr(op_addr));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string nm, input int ac, input int av, input int ec, input int ev);
      checks++;
      if (ac !== ec || av !== ev) begin
         errors++;
         $display("FAIL %s: got cycle %0d value %0h, required cycle %0d value %0h", nm, ac, av, ec, ev);
      end
   endtask

   task automatic take(input int idx, input string nm, input int av);
      ev_t e;
      if (qs[idx].size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: unexpected strobe at cycle %0d value %0h, required none", nm, cyc, av);
      end else begin
         e = qs[idx].pop_front();
         cmp(nm, cyc, av, e.c, e.v);
      end
   endtask

   task automatic push(input int idx, input int c, input int v, input int lim);
      if (c <= lim) qs[idx].push_back('{t0 + c, v});
   endtask

   task automatic check_zero(input string nm);
      cmp(nm, cyc, int'(|{busy, done, wt_rd_en, wt_addr, inp_rd_en, inp_addr, mac_load_wt,
                        mac_valid, acc_reset, acc_sel, op_wr_en, op_addr}), cyc, 0);
   endtask

   // Monitor: busy every cycle, and each strobe against the head of its queue.
   always @(negedge clk) begin
      cmp("busy", cyc, int'(busy), cyc, int'(cyc >= bw_s && cyc <= bw_e));
      if (wt_rd_en)    take(0, "wt_addr", int'(wt_addr));
      if (inp_rd_en)   take(1, "inp_addr", int'(inp_addr));
      if (op_wr_en)    take(2, "op_sel_addr", int'({acc_sel, op_addr}));
      if (mac_load_wt) take(3, "mac_load_wt", 0);
      if (mac_valid)   take(4, "mac_valid", 0);
      if (acc_reset)   take(5, "acc_reset", 0);
      if (done)        take(6, "done", 0);
   end

   // act: 0 plain, 1 re-pulse start and change cfg mid-STREAM, 2 abort in cycle a,
   // 3 async reset during cycle a. Called at a negedge; cycle c is sampled at cyc == t0+c.
   task automatic run_tile(input int k, input int wb, input int ib, input int ob,
                           input int act, input int a);
      int lim, tend;
      bit stop;
      tend = 4 * N + k + 1;
      t0   = cyc;
      lim  = (act == 2) ? a : (act == 3) ? a - 1 : tend;
      if (k != 0) begin
         for (int r = 0; r < N; r++) begin
            push(0, 1 + r, (wb + r) & 32'h7fff, lim);
            push(3, 2 + r, 0, lim);
         end
         push(5, 1, 0, lim);
         for (int i = 0; i < k; i++) begin
            push(1, N + 1 + i, (ib + i) & 32'h7fff, lim);
            push(4, N + 2 + i, 0, lim);
         end
         for (int j = 0; j < N; j++) push(2, 3 * N + k + 1 + j, (j << 4) | ((ob + j) & 32'hf), lim);
         push(6, tend, 0, lim);
         bw_s = t0 + 1;
         bw_e = t0 + lim;
      end
      cfg_k        = KW'(k);
      cfg_wt_base  = 15'(wb);
      cfg_inp_base = 15'(ib);
      cfg_op_base  = 4'(ob);
      start        = 1'b1;
      stop         = 1'b0;
      for (int c = 1; c <= tend + 3 && !stop; c++) begin
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         if (act == 1 && c == 7) begin
            start        = 1'b1;
            cfg_k        = 8'd3;
            cfg_wt_base  = 15'h5555;
            cfg_inp_base = 15'h2aaa;
            cfg_op_base  = 4'd9;
         end
         if (act == 2 && c == a) abort = 1'b1;
         if (act == 3 && c == a - 1) begin
            @(posedge clk);
            #2 rst = 1'b1;
            #1 check_zero("rst_async_zero");
            @(negedge clk);
            @(negedge clk);
            rst  = 1'b0;
            stop = 1'b1;
         end
      end
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check_zero("idle_zero");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check_zero("reset_zero");
      rst = 1'b0;
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      run_tile(8, 'h100, 'h200, 2, 0, 0);
      run_tile(0, 'h100, 'h200, 2, 0, 0);
      run_tile(3, 'h7ffe, 'h7fff, 14, 0, 0);
      run_tile(8, 'h040, 'h300, 5, 1, 0);
      run_tile(8, 'h010, 'h020, 7, 2, 15);
      run_tile(5, 'h011, 'h021, 3, 0, 0);
      run_tile(8, 'h600, 'h700, 0, 3, 8);
      run_tile(2, 'h001, 'h002, 1, 0, 0);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 7; i++) cmp("leftover_events", i, qs[i].size(), i, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
